// File: rtl/pt_byte_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : pt_byte_packer_if
// Description : Signal bundle for pt_byte_packer. It carries the serial
//               plaintext input (pt_in, pt_vld_in), the valid/ready byte
//               output (m_data, m_last, m_valid, m_ready) and the status
//               outputs (blk_done, frm_err, ovf, fifo_level).
//               modport master : the packer side (drives the byte bus)
//               modport slave  : the environment side (drives the bit stream
//                                and m_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface pt_byte_packer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               pt_in;
  logic               pt_vld_in;
  logic [7:0]         m_data;
  logic               m_last;
  logic               m_valid;
  logic               m_ready;
  logic               blk_done;
  logic               frm_err;
  logic               ovf;
  logic [c_LVL_W-1:0] fifo_level;

  modport master (
    input  pt_in, pt_vld_in, m_ready,
    output m_data, m_last, m_valid, blk_done, frm_err, ovf, fifo_level
  );

  modport slave (
    output pt_in, pt_vld_in, m_ready,
    input  m_data, m_last, m_valid, blk_done, frm_err, ovf, fifo_level
  );
endinterface
`default_nettype wire

// File: rtl/pt_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : pt_byte_packer
// Description : Re-packs the serial AES plaintext stream into bytes and
//               queues them in a byte FIFO feeding a valid/ready interface.
//               Bytes are LSB-first on the wire; the 16th byte of each
//               128-bit block is tagged with m_last. Truncated blocks pulse
//               frm_err; bytes lost to a full FIFO set the sticky ovf flag.
// Ports       : clk, rst (sync, active-high)
//               bus.pt_in / bus.pt_vld_in    serial plaintext in
//               bus.m_data / m_last / m_valid / m_ready  byte out
//               bus.blk_done, bus.frm_err    one-cycle status pulses
//               bus.ovf                      sticky overflow
//               bus.fifo_level               FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module pt_byte_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  pt_byte_packer_if.master bus
);
  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int                 c_LVL_W = c_PTR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL  = c_LVL_W'(FIFO_DEPTH);

  logic [7:0]         r_sr;
  logic [6:0]         r_bit_cnt;
  logic [8:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               r_ovf;
  logic               r_blk_done;
  logic               r_frm_err;

  logic [7:0]         w_byte;
  logic               w_byte_done;
  logic               w_last;
  logic               w_empty;
  logic               w_full;
  logic               w_rd;
  logic               w_wr;
  logic               w_drop;
  logic               w_trunc;

  // Completed byte: the current bit becomes the MSB, earlier bits shift down.
  assign w_byte      = {bus.pt_in, r_sr[7:1]};
  assign w_byte_done = bus.pt_vld_in && (r_bit_cnt[2:0] == 3'd7);
  assign w_last      = (r_bit_cnt == 7'd127);
  assign w_trunc     = !bus.pt_vld_in && (r_bit_cnt != 7'd0);

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_FULL);
  assign w_rd    = !w_empty && bus.m_ready;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_wr    = w_byte_done && (!w_full || w_rd);
  assign w_drop  = w_byte_done && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= 8'h00;
      r_bit_cnt  <= 7'd0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
      r_blk_done <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_blk_done <= bus.pt_vld_in && w_last;
      r_frm_err  <= w_trunc;

      if (bus.pt_vld_in) begin
        r_sr      <= w_byte;
        r_bit_cnt <= r_bit_cnt + 7'd1;
      end else if (w_trunc) begin
        r_sr      <= 8'h00;
        r_bit_cnt <= 7'd0;
      end

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_last, w_byte};
    end
  end

  assign bus.m_valid    = !w_empty;
  assign bus.m_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
  assign bus.m_last     = w_empty ? 1'b0  : r_mem[r_rd_ptr][8];
  assign bus.blk_done   = r_blk_done;
  assign bus.frm_err    = r_frm_err;
  assign bus.ovf        = r_ovf;
  assign bus.fifo_level = r_level;
endmodule
`default_nettype wire

// File: tb/tb_pt_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pt_byte_packer
// Description : Self-checking bench for pt_byte_packer. A queue-based model
//               of the byte stream predicts every output each cycle; directed
//               scenarios add literal expectations, followed by random
//               traffic with gaps, truncations, stalls and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pt_byte_packer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pt_byte_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

  pt_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: queued entries {last, byte}, bits of the byte in progress,
  // bits seen in the current block, and the status flags.
  logic [8:0] q[$];
  bit         bits[$];
  int         n_blk;
  bit         m_ovf;
  bit         m_blk;
  bit         m_frm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    bits.delete();
    n_blk = 0;
    m_ovf = 1'b0;
    m_blk = 1'b0;
    m_frm = 1'b0;
  endtask

  task automatic model_edge(input bit pt, input bit vld, input bit rdy);
    logic [7:0] b;
    bit rd;
    rd    = (q.size() > 0) && rdy;
    m_blk = 1'b0;
    m_frm = 1'b0;
    if (rd) void'(q.pop_front());
    if (vld) begin
      bits.push_back(pt);
      n_blk++;
      if (bits.size() == 8) begin
        for (int i = 0; i < 8; i++) b[i] = bits[i];
        bits.delete();
        if (q.size() < DEPTH) q.push_back({(n_blk == 128), b});
        else m_ovf = 1'b1;
      end
      if (n_blk == 128) begin
        m_blk = 1'b1;
        n_blk = 0;
      end
    end else if (n_blk != 0) begin
      m_frm = 1'b1;
      n_blk = 0;
      bits.delete();
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic step(input bit pt, input bit vld, input bit rdy);
    bus.pt_in     = pt;
    bus.pt_vld_in = vld;
    bus.m_ready   = rdy;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(pt, vld, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic feed_block(input logic [127:0] blk, input bit rdy);
    for (int i = 0; i < 128; i++) step(blk[i], 1'b1, rdy);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      if (q.size() > 0) begin
        chk("m_valid", bus.m_valid, 1);
        chk("m_data",  bus.m_data,  q[0][7:0]);
        chk("m_last",  bus.m_last,  q[0][8]);
      end else begin
        chk("m_valid", bus.m_valid, 0);
        chk("m_data",  bus.m_data,  0);
        chk("m_last",  bus.m_last,  0);
      end
      chk("fifo_level", bus.fifo_level, q.size());
      chk("ovf",        bus.ovf,        m_ovf);
      chk("blk_done",   bus.blk_done,   m_blk);
      chk("frm_err",    bus.frm_err,    m_frm);
    end
  end

  logic [127:0] c_blk;
  logic [127:0] r_blk;

  initial begin
    c_blk = 128'h000102030405060708090A0B0C0D0E0F;
    bus.pt_in = 1'b0;
    bus.pt_vld_in = 1'b0;
    bus.m_ready = 1'b0;
    model_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    rst = 1'b0;
    chk("reset_level", bus.fifo_level, 0);
    chk("reset_valid", bus.m_valid, 0);

    // Single block, consumer always ready.
    for (int i = 0; i < 128; i++) begin
      step(c_blk[i], 1'b1, 1'b1);
      if (i == 7) chk("first_byte", bus.m_data, 8'h0F);
    end
    chk("blk_done_pulse", bus.blk_done, 1);
    chk("last_byte", bus.m_data, 8'h00);
    chk("last_flag", bus.m_last, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("blk_done_single", bus.blk_done, 0);

    // Exact fit under back-pressure, then drain.
    feed_block(c_blk, 1'b0);
    for (int i = 0; i < 72; i++) step(1'b0, 1'b0, 1'b0);
    chk("fit_level", bus.fifo_level, 16);
    chk("fit_ovf", bus.ovf, 0);
    for (int i = 0; i < 16; i++) begin
      chk("fit_drain", bus.m_data, 15 - i);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("fit_empty", bus.fifo_level, 0);

    // Overflow with two back-to-back blocks.
    feed_block(c_blk, 1'b0);
    feed_block(~c_blk, 1'b0);
    chk("ovf_set", bus.ovf, 1);
    chk("ovf_level", bus.fifo_level, 16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", bus.m_data, 15 - i);
      chk("ovf_last", bus.m_last, (i == 15));
      step(1'b0, 1'b0, 1'b1);
    end
    chk("ovf_sticky", bus.ovf, 1);
    do_reset();
    chk("ovf_cleared", bus.ovf, 0);

    // Truncated frame followed by a good block.
    for (int i = 0; i < 20; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("trunc_frm_err", bus.frm_err, 1);
    chk("trunc_bytes", bus.fifo_level, 2);
    step(1'b0, 1'b0, 1'b1);
    chk("trunc_frm_once", bus.frm_err, 0);
    feed_block(c_blk, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Full FIFO with a read landing on the byte-completion cycle.
    do_reset();
    feed_block(c_blk, 1'b0);
    for (int i = 0; i < 8; i++) step(c_blk[i], 1'b1, (i == 7));
    chk("fullrw_level", bus.fifo_level, 16);
    chk("fullrw_ovf", bus.ovf, 0);
    chk("fullrw_head", bus.m_data, 8'h0E);
    for (int i = 8; i < 128; i++) step(c_blk[i], 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);

    // Reset mid-block with three bytes queued.
    do_reset();
    for (int i = 0; i < 60; i++) step(c_blk[i], 1'b1, (i < 36));
    chk("mid_level", bus.fifo_level, 3);
    do_reset();
    chk("mid_rst_valid", bus.m_valid, 0);
    chk("mid_rst_frm", bus.frm_err, 0);
    r_blk = {$urandom, $urandom, $urandom, $urandom};
    feed_block(r_blk, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int b = 0; b < 40; b++) begin
      int stall;
      int cut;
      r_blk = {$urandom, $urandom, $urandom, $urandom};
      stall = $urandom_range(0, 3);
      cut   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 127) : 128;
      for (int i = 0; i < cut; i++)
        step(r_blk[i], 1'b1, (stall == 0) ? 1'b0 : ($urandom_range(0, stall) != 0));
      for (int g = $urandom_range(0, 4); g > 0; g--)
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pt_byte_packer.md
# pt_byte_packer

Downstream stage of the serial AES decrypt top. It takes the single-bit plaintext stream (`pt` / `pt_vld`) produced after each 128-bit decrypt and re-packs it into bytes. The bytes go through an internal byte FIFO to a valid/ready byte interface, with an end-of-block tag on the last byte. It also flags truncated frames and FIFO overflow, so the byte consumer can back-pressure without stalling the decrypt core.

## Interface
- `FIFO_DEPTH`, 16: byte FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pt_in`  in  1  serial plaintext bit.
- `pt_vld_in`  in  1  `pt_in` valid this cycle; high for exactly 128 consecutive cycles per block when well-formed.
- `m_data`  out  8  output byte (FIFO head).
- `m_last`  out  1  head byte is the 16th byte of a block.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts head when `m_valid & m_ready`.
- `blk_done`  out  1  one-cycle pulse: 128th bit of a block sampled.
- `frm_err`  out  1  one-cycle pulse: block truncated.
- `ovf`  out  1  sticky: a completed byte was dropped because the FIFO was full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Bit order.** The stream arrives as block bit 127 first, down to bit 0, with bit 0 being the MSB in [0:127] numbering.
  - Arrival bit n is block bit 127−n.
  - Byte j (j = 0..15, in arrival order) is block byte 15−j.
  - The first-arriving bit of each byte is the byte's LSB.
- **Byte assembly.** 8-bit shift register: `sr <= {pt_in, sr[7:1]}` on each valid bit.
- **Bit counter.** 7-bit `bit_cnt` increments on each valid bit and wraps 127→0.
- **Byte completion.** When `pt_vld_in=1` and `bit_cnt[2:0]=7`:
  - The byte `{pt_in, sr[7:1]}` is written to the FIFO at that edge.
  - The FIFO entry's last flag = (`bit_cnt`==127).
- **`blk_done`.** Registered pulse, asserted the cycle after the edge that sampled bit 127.
- **Truncation.** If `pt_vld_in=0` while `bit_cnt≠0`:
  - `bit_cnt` clears to 0 and the partial byte is discarded.
  - `frm_err` pulses for one cycle, in the next cycle.
  - Bytes already queued stay in the FIFO; none of them carries `m_last`.
- **Gaps.** `pt_vld_in=0` with `bit_cnt=0` is idle; no effect.
- **FIFO.** Registered, no empty bypass. Each entry is 9 bits: data plus last flag.
  - Read happens when `m_valid & m_ready`.
  - Write while full is accepted if a read occurs in the same cycle.
  - Otherwise the byte is dropped and `ovf` sets; `bit_cnt` keeps counting.
  - `ovf` clears only on `rst`.
- **Level.** `fifo_level` = writes − reads, range 0..FIFO_DEPTH. A simultaneous read and write leaves the level unchanged.
- **Reset values.** `rst` clears `sr`, `bit_cnt`, FIFO pointers and level, `ovf`, `blk_done` and `frm_err`. After reset all outputs are 0, including `m_data` and `m_last`.
- **Reset mid-block.** Partial bits and FIFO contents are discarded without `frm_err`. The next `pt_vld_in` bit is treated as arrival bit 0.

## Timing
- **Byte latency.** 8th bit sampled at edge E → `m_valid`=1 and `m_data` valid after E (one register stage).
- **Block.** 128 bit cycles → 16 FIFO writes, one every 8 cycles.
  - `blk_done` is high in the cycle after the 128th bit.
  - The 16th byte is at FIFO tail in the same cycle.
- **Throughput.** With `m_ready` held high, the FIFO never exceeds 1 entry.
- **Back-to-back blocks.** `pt_vld_in` may stay high across the block boundary; `bit_cnt` wraps with no gap cycle required.
- **Handshake.**
  - `m_data`/`m_last` hold stable while `m_valid & !m_ready`.
  - `m_valid` never drops without a handshake, except on `rst`.
- **Full-plus-read cycle.** Write and read in the same cycle with the FIFO full: the write lands in the slot freed by the read, and `ovf` stays 0.

## Test plan
- **Single block.** Block = 0x000102030405060708090A0B0C0D0E0F, fed 128 cycles in hardware order, `m_ready`=1.
  - Bytes out: 0F,0E,…,01,00.
  - `m_last` only on 00.
  - `blk_done` pulses once, the cycle after bit 128.
  - `ovf`=0, `frm_err`=0.
- **Back-pressure, exact fit.** One block, `m_ready`=0 for 200 cycles, `FIFO_DEPTH`=16.
  - `fifo_level` reaches 16, `ovf` stays 0.
  - Release `m_ready` → 16 bytes drain in 16 cycles, with `m_data` stable while stalled.
- **Overflow.** Two back-to-back blocks with `m_ready`=0.
  - `fifo_level`=16 and `ovf`=1 from the 17th byte onward.
  - Drained bytes are the first block only, 0F..00 with last on 00.
  - `ovf` stays 1 until `rst`.
- **Truncation.** `pt_vld_in` high for 20 cycles, then low.
  - Exactly 2 bytes out, no `m_last`.
  - `frm_err` pulses once, the cycle after `pt_vld_in` falls.
  - A following full block decodes correctly.
- **Full + simultaneous read/write.** Fill FIFO to 16, then assert `m_ready` on the cycle the next byte completes.
  - Level stays 16, `ovf`=0, byte order preserved.
- **Reset mid-block.** Assert `rst` at bit 60 with 3 bytes queued.
  - All outputs 0 the next cycle, no `frm_err`.
  - A subsequent full block produces 16 correct bytes.
